// File: rtl/serial_sub_pkg.sv
// Shared state encoding and default width for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = x - y - bin, bout on underflow.
// Zero latency; no flow control.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first; done after WIDTH+1 cycles, start ignored while busy.
// SERIAL_SUB_OVERFLOW_EN adds the signed overflow flag (ovf tied to 0 otherwise).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;
  logic load, step, last;

  logic [WIDTH-1:0] ra, rb;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CNT_W-1:0] cnt;
  logic bin, d, bout;

  full_subtractor u_cell (
    .x    (ra[0]),
    .y    (rb[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  // res holds the WIDTH-1 bits already produced; the final bit joins on the way to diff
  assign res_nxt = {d, res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (load) begin
      ra  <= a;
      rb  <= b;
      res <= '0;
      cnt <= '0;
      bin <= 1'b0;
    end else if (step) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      res <= res_nxt[WIDTH-1:1];
      bin <= bout;
      // hold on the final bit so cnt never wraps for power-of-two widths
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        diff   <= res_nxt;
        borrow <= bout;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb, b_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last) begin
      // d is the result MSB on the final step
      ovf <= (a_msb ^ b_msb) & (d ^ a_msb);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
